mole_spawner: RTL and testbench

//  Game-control stage directly downstream of the 16-bit PRBS generator. Requests one LFSR

---
 rtl/whack_pkg.sv | 28 ++
 rtl/mole_tick_timer.sv | 30 +++
 rtl/mole_spawner.sv | 153 +++++++++++++++
 tb/tb_mole_spawner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game controller: FSM state
// encoding, the bit fields taken from the PRBS word, and the hole-wrap helper.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        GAP  = 2'd2,
        UP   = 2'd3
    } state_t;

    localparam int HOLE_LSB = 0;
    localparam int GAP_LSB  = 4;
    localparam int LIFE_LSB = 8;
    localparam int FIELD_W  = 4;

    // Folds a 4-bit random value into 0..numHoles-1. numHoles is at least 8,
    // so a single subtraction is always enough.
    function automatic logic [3:0] wrapHole(input logic [3:0] raw, input int numHoles);
        logic [4:0] wide;
        wide = {1'b0, raw};
        if (wide >= 5'(numHoles)) begin
            wide = wide - 5'(numHoles);
        end
        return wide[3:0];
    endfunction

endpackage

// File: rtl/mole_tick_timer.sv
// Loadable down-counter advanced by the game tick. "last" flags the tick on
// which the count leaves 1, i.e. the tick that ends the interval. The count
// saturates at 0 and is only ever reloaded through load.
module mole_tick_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         tick,
    output logic         last
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down once per tick until empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = tick && (count == W'(1));

endmodule

// File: rtl/mole_spawner.sv
// Game-control stage fed by the 16-bit PRBS generator. Each round it requests
// one PRBS shift, picks a hole, waits a random gap, lights the mole for a
// random lifetime and scores the round as a hit or a miss.
// Optional build macro: NO_REPEAT_EN -- when defined, a hole never repeats
// in two consecutive rounds (a repeat is bumped to the next hole, wrapping).
module mole_spawner
    import whack_pkg::*;
#(
    parameter int NUM_HOLES = 9,
    parameter int GAP_MIN   = 4,
    parameter int UP_MIN    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [15:0]          rand_seq,
    output logic                 shift_en,
    input  logic [NUM_HOLES-1:0] whack,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic                 hit,
    output logic                 miss
);

    localparam int GAP_W  = $clog2(GAP_MIN + 16);
    localparam int LIFE_W = $clog2(UP_MIN + 16);

    state_t      state;
    logic [3:0]  holeReg;
    logic [3:0]  rawHole;
    logic [3:0]  pickHole;
    logic        pickNow;
    logic        gapTick;
    logic        lifeTick;
    logic        gapLast;
    logic        lifeLast;
    logic        hitNow;
    logic [GAP_W-1:0]  gapLoad;
    logic [LIFE_W-1:0] lifeLoad;

    // The top nibble of the PRBS word carries no game field.
    wire unusedRandHigh = ^rand_seq[15:12];

`ifdef NO_REPEAT_EN
    logic [3:0] prevHole;
`endif

    assign pickNow  = enable && (state == PICK);
    assign gapTick  = enable && tick && (state == GAP);
    assign lifeTick = enable && tick && (state == UP);
    assign hitNow   = (state == UP) && (|(whack & mole_onehot));

    assign gapLoad  = GAP_W'(GAP_MIN)  + GAP_W'(rand_seq[GAP_LSB +: FIELD_W]);
    assign lifeLoad = LIFE_W'(UP_MIN)  + LIFE_W'(rand_seq[LIFE_LSB +: FIELD_W]);

    // Hole selection from the current PRBS word, with optional repeat avoidance.
    always_comb begin
        rawHole  = wrapHole(rand_seq[HOLE_LSB +: FIELD_W], NUM_HOLES);
        pickHole = rawHole;
`ifdef NO_REPEAT_EN
        if (rawHole == prevHole) begin
            pickHole = (rawHole == 4'(NUM_HOLES - 1)) ? 4'd0 : rawHole + 4'd1;
        end
`endif
    end

    mole_tick_timer #(
        .W(GAP_W)
    ) gapTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (pickNow),
        .loadValue (gapLoad),
        .tick      (gapTick),
        .last      (gapLast)
    );

    mole_tick_timer #(
        .W(LIFE_W)
    ) lifeTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (pickNow),
        .loadValue (lifeLoad),
        .tick      (lifeTick),
        .last      (lifeLast)
    );

    // Round sequencing and all registered outputs; a hit outranks an expiring tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            holeReg     <= '0;
            shift_en    <= 1'b0;
            mole_onehot <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
        end else begin
            shift_en <= 1'b0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            if (!enable) begin
                state       <= IDLE;
                mole_onehot <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= PICK;
                        shift_en <= 1'b1;
                    end
                    PICK: begin
                        holeReg <= pickHole;
                        state   <= GAP;
                    end
                    GAP: begin
                        if (gapLast) begin
                            state       <= UP;
                            mole_onehot <= NUM_HOLES'(1) << holeReg;
                        end
                    end
                    UP: begin
                        if (hitNow) begin
                            hit         <= 1'b1;
                            mole_onehot <= '0;
                            state       <= PICK;
                            shift_en    <= 1'b1;
                        end else if (lifeLast) begin
                            miss        <= 1'b1;
                            mole_onehot <= '0;
                            state       <= PICK;
                            shift_en    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef NO_REPEAT_EN
    // Remembers the hole of the round just picked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prevHole <= '0;
        end else if (pickNow) begin
            prevHole <= pickHole;
        end
    end
`endif

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: the stimulus pushes each expected output
// event into a queue; a monitor pops and compares whenever an output event
// appears (shift_en, hit, miss pulse or a change of mole_onehot).
module tb_mole_spawner;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        tick;
    logic [15:0] rand_seq;
    logic        shift_en;
    logic [8:0]  whack;
    logic [8:0]  mole_onehot;
    logic        hit;
    logic        miss;

    typedef struct {
        string      name;
        logic [8:0] mole;
        logic       hit;
        logic       miss;
        logic       shift;
    } expEvent_t;

    expEvent_t expQ[$];
    int  testsRun    = 0;
    int  testsFailed = 0;
    bit  monitorOn   = 0;
    logic [8:0] prevMole = '0;

    mole_spawner #(
        .NUM_HOLES (9),
        .GAP_MIN   (4),
        .UP_MIN    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .rand_seq    (rand_seq),
        .shift_en    (shift_en),
        .whack       (whack),
        .mole_onehot (mole_onehot),
        .hit         (hit),
        .miss        (miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input string name, input logic [8:0] m, input logic h, input logic mi, input logic s);
        expEvent_t e;
        e.name  = name;
        e.mole  = m;
        e.hit   = h;
        e.miss  = mi;
        e.shift = s;
        expQ.push_back(e);
    endtask

    // One tick slot: the pulse cycle followed by one quiet cycle.
    task automatic applyStimulus(input logic t, input logic [8:0] w);
        tick  = t;
        whack = w;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        whack = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output event is matched against the head of the queue.
    initial begin
        expEvent_t e;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                if (shift_en || hit || miss || (mole_onehot !== prevMole)) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected_event: got mole=%h hit=%b miss=%b shift=%b, expected no event",
                                 mole_onehot, hit, miss, shift_en);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({e.name, " {mole,hit,miss,shift}"},
                                    {20'd0, mole_onehot, hit, miss, shift_en},
                                    {20'd0, e.mole, e.hit, e.miss, e.shift});
                    end
                end
            end
            prevMole = mole_onehot;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        enable   = 1'b0;
        tick     = 1'b0;
        whack    = '0;
        rand_seq = 16'h0A35;
        waitCycles(3);

        checkOutput("reset_mole",  {23'd0, mole_onehot}, 32'd0);
        checkOutput("reset_hit",   {31'd0, hit},         32'd0);
        checkOutput("reset_miss",  {31'd0, miss},        32'd0);
        checkOutput("reset_shift", {31'd0, shift_en},    32'd0);
        monitorOn = 1;

        // Round 1: 0A35 -> hole 5, gap 7, life 18.
        enable = 1'b1;
        pushExp("t1_pick", 9'h000, 1'b0, 1'b0, 1'b1);
        pushExp("t1_up",   9'h020, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        waitCycles(2);
        repeat (6) applyStimulus(1'b1, 9'h000);
        checkOutput("t1_dark_after_6_ticks", {23'd0, mole_onehot}, 32'd0);
        applyStimulus(1'b1, 9'h000);

        // Hit coinciding with the expiring tick; next word 0A0C -> hole 3, gap 4, life 18.
        repeat (17) applyStimulus(1'b1, 9'h000);
        rand_seq = 16'h0A0C;
        pushExp("t3_hit_wins", 9'h000, 1'b1, 1'b0, 1'b1);
        pushExp("t2_up_hole3", 9'h008, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h020);

        // Round 2 gap: whacks during GAP are ignored.
        applyStimulus(1'b1, 9'h008);
        applyStimulus(1'b0, 9'h008);
        repeat (3) applyStimulus(1'b1, 9'h000);

        // Only other holes whacked: miss on the 18th tick; next word 0312 -> hole 2, gap 5, life 11.
        applyStimulus(1'b0, 9'h001);
        repeat (17) applyStimulus(1'b1, 9'h020);
        rand_seq = 16'h0312;
        pushExp("t4_miss",     9'h000, 1'b0, 1'b1, 1'b1);
        pushExp("t5_up_hole2", 9'h004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h000);

        // Round 3: up after 5 ticks, then enable dropped mid-UP.
        repeat (5) applyStimulus(1'b1, 9'h000);
        repeat (3) applyStimulus(1'b1, 9'h000);
        pushExp("t5_disable_dark", 9'h000, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        whack  = 9'h004;
        waitCycles(1);
        whack  = '0;
        repeat (3) applyStimulus(1'b1, 9'h000);
        checkOutput("t5_idle_mole",  {23'd0, mole_onehot}, 32'd0);
        checkOutput("t5_idle_shift", {31'd0, shift_en},    32'd0);

        // Restart, then asynchronous reset in the middle of GAP.
        rand_seq = 16'h0000;
        pushExp("t5_restart_pick", 9'h000, 1'b0, 1'b0, 1'b1);
        enable = 1'b1;
        waitCycles(2);
        repeat (2) applyStimulus(1'b1, 9'h000);
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_mole",  {23'd0, mole_onehot}, 32'd0);
        checkOutput("t5_rst_hit",   {31'd0, hit},         32'd0);
        checkOutput("t5_rst_miss",  {31'd0, miss},        32'd0);
        checkOutput("t5_rst_shift", {31'd0, shift_en},    32'd0);
        waitCycles(2);

        // Repeat handling: 0008 -> hole 8, gap 4, life 8, picked twice in a row.
        rand_seq = 16'h0008;
        pushExp("t6_pick1",    9'h000, 1'b0, 1'b0, 1'b1);
        pushExp("t6_up_hole8", 9'h100, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        waitCycles(2);
        repeat (3) applyStimulus(1'b1, 9'h000);
        checkOutput("t6_dark_after_3_ticks", {23'd0, mole_onehot}, 32'd0);
        applyStimulus(1'b1, 9'h000);
        pushExp("t6_hit", 9'h000, 1'b1, 1'b0, 1'b1);
`ifdef NO_REPEAT_EN
        pushExp("t6_up_second", 9'h001, 1'b0, 1'b0, 1'b0);
`else
        pushExp("t6_up_second", 9'h100, 1'b0, 1'b0, 1'b0);
`endif
        applyStimulus(1'b0, 9'h100);
        repeat (4) applyStimulus(1'b1, 9'h000);
        pushExp("t6_disable_dark", 9'h000, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        waitCycles(4);

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
